// File: rtl/servo_pkg.sv
// Shared types and constants for the servo command arbiter.
package servo_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ARB    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam int          NUM_REQ        = 4;
    localparam logic [7:0]  PARK_RATIO_DEF = 8'h80;

endpackage

// File: rtl/servo_arbiter_rr.sv
// Round-robin winner select over 4 requesters, combinational.
// With SERVO_ARB_PRIORITY_EN defined, requester 0 always wins and 1-3 rotate among themselves.
module rr_arbiter
    import servo_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       valid
);

    logic [1:0] idx;

    always_comb begin
        winner = 2'd0;
        valid  = 1'b0;
        idx    = 2'd0;
`ifdef SERVO_ARB_PRIORITY_EN
        if (req[0]) begin
            valid = 1'b1;
        end
        // Index 0 is skipped in the scan so a last grant of 0 or 3 both restart at 1.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last + 2'(i);
            if (!valid && idx != 2'd0 && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
`else
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last + 2'(i);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/servo_arbiter.sv
// Grants one of 4 servo command requesters, then holds the servo for SETTLE_CYCLES before re-arbitrating.
// Optional SERVO_ARB_PRIORITY_EN gives requester 0 absolute priority.
module servo_arbiter
    import servo_pkg::*;
#(
    parameter logic [23:0] SETTLE_CYCLES = 24'd1_000_000,
    parameter logic [7:0]  PARK_RATIO    = PARK_RATIO_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable_in,
    input  logic [3:0]  req,
    input  logic [31:0] req_ratio,
    output logic [3:0]  ack,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        pwm_enable,
    output logic [7:0]  start_pwm_ratio,
    output logic [7:0]  target_pwm_ratio
);

    localparam logic [23:0] LAST_CNT = (SETTLE_CYCLES == 24'd0) ? 24'd0 : SETTLE_CYCLES - 24'd1;

    state_t      state, state_nxt;
    logic [23:0] cnt;
    logic [1:0]  win;
    logic        win_vld;
    logic        grant;

    rr_arbiter u_rr (
        .req    (req),
        .last   (grant_id),
        .winner (win),
        .valid  (win_vld)
    );

    assign start_pwm_ratio = PARK_RATIO;

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        pwm_enable = 1'b0;
        busy       = 1'b0;
        case (state)
            OFF: begin
                if (enable_in) state_nxt = ARB;
            end
            ARB: begin
                pwm_enable = 1'b1;
                if (!enable_in) begin
                    state_nxt = OFF;
                end else if (win_vld) begin
                    grant     = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                pwm_enable = 1'b1;
                busy       = 1'b1;
                // enable_in is deliberately not looked at until the command completes.
                if (cnt >= LAST_CNT) state_nxt = ARB;
            end
            default: state_nxt = OFF;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= OFF;
            cnt              <= 24'd0;
            ack              <= 4'd0;
            grant_id         <= 2'd3;
            target_pwm_ratio <= PARK_RATIO;
        end else begin
            state <= state_nxt;
            ack   <= 4'd0;
            if (grant) begin
                ack              <= 4'b0001 << win;
                grant_id         <= win;
                target_pwm_ratio <= req_ratio[{win, 3'b000} +: 8];
                cnt              <= 24'd0;
            end else if (state == SETTLE && cnt != 24'hFF_FFFF) begin
                cnt <= cnt + 24'd1;
            end
        end
    end

endmodule
